// File: rtl/wallace_pkg.sv
// Shared widths and row types for the 8x8 Wallace multiplier datapath.
// Rows are bit-aligned: bit i of both sum and carry carries weight 2^i.
package wallace_pkg;

  localparam int OP_W      = 8;
  localparam int PROD_W    = 2 * OP_W;
  localparam int CPA_SPLIT = 8;

  typedef logic [PROD_W-1:0] prod_t;

  typedef struct packed {
    prod_t sum;
    prod_t carry;
  } rows_t;

endpackage

// File: rtl/wallace_cpa_stage_rca_slice.sv
// W-bit ripple-carry adder slice built from full_adder cells; purely combinational.
// No latency and no flow control; the enclosing pipeline decides when results are captured.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module rca_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[W];

endmodule

// File: rtl/wallace_cpa_stage.sv
// Final Wallace carry-propagate adder: low SPLIT bits in stage 1, high bits in stage 2; 2-cycle latency.
// in_ready follows out_ready combinationally (no skid buffer); macro CPA_OVF_FLAG_EN builds ovf_sticky.
module wallace_cpa_stage
  import wallace_pkg::*;
#(
  parameter int WIDTH = PROD_W,
  parameter int SPLIT = CPA_SPLIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_product,
  output logic             out_cout,
  output logic             ovf_sticky
);

  localparam int HI_W = WIDTH - SPLIT;

  logic             s1_valid;
  logic [SPLIT-1:0] s1_lo;
  logic             s1_cmid;
  logic [HI_W-1:0]  s1_sum_hi;
  logic [HI_W-1:0]  s1_carry_hi;
  logic             s2_valid;

  logic [SPLIT-1:0] lo_sum;
  logic             lo_cout;
  logic [HI_W-1:0]  hi_sum;
  logic             hi_cout;

  logic in_xfer;
  logic out_xfer;
  logic s2_adv;

  assign s2_adv    = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_adv;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_xfer  = s2_valid && out_ready;

  rca_slice #(.W(SPLIT)) u_lo (
    .a    (in_sum[SPLIT-1:0]),
    .b    (in_carry[SPLIT-1:0]),
    .cin  (1'b0),
    .s    (lo_sum),
    .cout (lo_cout)
  );

  // High half consumes the registered carry from the low half.
  rca_slice #(.W(HI_W)) u_hi (
    .a    (s1_sum_hi),
    .b    (s1_carry_hi),
    .cin  (s1_cmid),
    .s    (hi_sum),
    .cout (hi_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_lo       <= '0;
      s1_cmid     <= 1'b0;
      s1_sum_hi   <= '0;
      s1_carry_hi <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid    <= 1'b1;
        s1_lo       <= lo_sum;
        s1_cmid     <= lo_cout;
        s1_sum_hi   <= in_sum[WIDTH-1:SPLIT];
        s1_carry_hi <= in_carry[WIDTH-1:SPLIT];
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      out_product <= '0;
      out_cout    <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid    <= 1'b1;
        out_product <= {hi_sum, s1_lo};
        out_cout    <= hi_cout;
      end else if (out_xfer) begin
        s2_valid <= 1'b0;
      end
    end
  end

`ifdef CPA_OVF_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (out_xfer && out_cout) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_sticky = ovf_q;
`else
  assign ovf_sticky = 1'b0;
`endif

endmodule
